// File: rtl/noc_ni_inject.sv
// noc_ni_inject: NoC network-interface injection stage.
// Packs core requests into 20-bit flits, buffers them in a local FIFO and
// releases them to one router input port under credit-based flow control.
// Optional statistics outputs (sent_cnt, stall_cnt) are present when the
// macro NI_STATS_EN is defined.
module noc_ni_inject #(
  parameter int FIFO_DEPTH = 4,
  parameter int CREDITS    = 4,
  parameter int CNT_W      = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          core_valid,
  output logic                          core_ready,
  input  logic [1:0]                    core_dst_cluster,
  input  logic [1:0]                    core_dst_local,
  input  logic [15:0]                   core_data,
  input  logic                          ci,
  output logic [19:0]                   flit_out,
  output logic                          flit_valid,
  output logic [CNT_W-1:0]              credit_cnt,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          credit_err
`ifdef NI_STATS_EN
  ,
  output logic [15:0]                   sent_cnt,
  output logic [15:0]                   stall_cnt
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, ACTIVE, STALL} state_t;

  state_t             state_q, state_d;
  logic [19:0]        mem [FIFO_DEPTH];
  logic [AW-1:0]      wr_ptr, rd_ptr;
  logic [AW:0]        count_d;
  logic [CNT_W-1:0]   credit_d;
  logic               err_d;
  logic               push, send;

  assign core_ready = (fifo_count != (AW+1)'(FIFO_DEPTH));
  assign push       = core_valid && core_ready;
  assign send       = (fifo_count != '0) && (credit_cnt != '0);

  // Next FIFO occupancy, credit count, error flag and FSM state.
  always_comb begin
    count_d  = fifo_count;
    credit_d = credit_cnt;
    err_d    = credit_err;
    state_d  = state_q;

    if (push && !send)      count_d = fifo_count + 1'b1;
    else if (send && !push) count_d = fifo_count - 1'b1;

    // A returned credit coinciding with a send cancels out.
    if (send && !ci) begin
      credit_d = credit_cnt - 1'b1;
    end else if (ci && !send) begin
      if (credit_cnt == CNT_W'(CREDITS)) err_d = 1'b1;
      else                               credit_d = credit_cnt + 1'b1;
    end

    unique case (state_q)
      IDLE:    if (count_d != '0) state_d = (credit_d == '0) ? STALL : ACTIVE;
      ACTIVE:  if (count_d == '0)       state_d = IDLE;
               else if (credit_d == '0) state_d = STALL;
      STALL:   if (ci) state_d = ACTIVE;
      default: state_d = IDLE;
    endcase
  end

  // Control registers: pointers, occupancy, credits, output flit, FSM state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      credit_cnt <= CNT_W'(CREDITS);
      credit_err <= 1'b0;
      flit_out   <= '0;
      flit_valid <= 1'b0;
      state_q    <= IDLE;
    end else begin
      fifo_count <= count_d;
      credit_cnt <= credit_d;
      credit_err <= err_d;
      state_q    <= state_d;
      flit_valid <= send;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (send) begin
        rd_ptr   <= rd_ptr + 1'b1;
        flit_out <= mem[rd_ptr];
      end
    end
  end

  // FIFO storage; contents are don't-care while the slot is unoccupied.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {core_dst_cluster, core_dst_local, core_data};
  end

`ifdef NI_STATS_EN
  // Statistics counters, wrapping at 16 bits.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sent_cnt  <= '0;
      stall_cnt <= '0;
    end else begin
      if (flit_valid)       sent_cnt  <= sent_cnt + 16'd1;
      if (state_q == STALL) stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_noc_ni_inject.sv
// Self-checking bench for noc_ni_inject: a queue-based reference model is
// compared against the DUT every cycle, plus hand-computed directed checks.
module tb_noc_ni_inject;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        core_valid = 1'b0;
  logic        core_ready;
  logic [1:0]  core_dst_cluster = '0;
  logic [1:0]  core_dst_local = '0;
  logic [15:0] core_data = '0;
  logic        ci = 1'b0;
  logic [19:0] flit_out;
  logic        flit_valid;
  logic [2:0]  credit_cnt;
  logic [2:0]  fifo_count;
  logic        credit_err;

  int unsigned tests = 0;
  int unsigned fails = 0;

  noc_ni_inject #(.FIFO_DEPTH(4), .CREDITS(4), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .core_valid(core_valid), .core_ready(core_ready),
    .core_dst_cluster(core_dst_cluster), .core_dst_local(core_dst_local),
    .core_data(core_data), .ci(ci), .flit_out(flit_out),
    .flit_valid(flit_valid), .credit_cnt(credit_cnt),
    .fifo_count(fifo_count), .credit_err(credit_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: request queue plus an integer credit counter.
  logic [19:0] q[$];
  int          mcred = 4;
  bit          merr = 0;
  bit          mvalid = 0;
  logic [19:0] mflit = '0;
  bit          chk = 0;
  bit          mpush, msend;

  always @(posedge clk) begin
    if (!rst) begin
      q.delete();
      mcred  = 4;
      merr   = 0;
      mvalid = 0;
      mflit  = '0;
      chk    = 1;
    end else begin
      mpush = core_valid && (q.size() < 4);
      msend = (q.size() > 0) && (mcred > 0);
      if (msend) begin
        mflit  = q.pop_front();
        mvalid = 1;
      end else begin
        mvalid = 0;
      end
      if (mpush) q.push_back({core_dst_cluster, core_dst_local, core_data});
      if (ci && !msend) begin
        if (mcred == 4) merr = 1;
        else            mcred++;
      end else if (msend && !ci) begin
        mcred--;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk) begin
      check("flit_valid", 32'(flit_valid), 32'(mvalid));
      check("flit_out",   32'(flit_out),   32'(mflit));
      check("credit_cnt", 32'(credit_cnt), 32'(mcred));
      check("fifo_count", 32'(fifo_count), 32'(q.size()));
      check("core_ready", 32'(core_ready), 32'(q.size() < 4));
      check("credit_err", 32'(credit_err), 32'(merr));
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    ci = 1'b0;
    core_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  // Drive one request; returns on the negedge after the accepting edge.
  task automatic push(input logic [1:0] cl, input logic [1:0] lo, input logic [15:0] d);
    int unsigned waited = 0;
    core_valid = 1'b1;
    core_dst_cluster = cl;
    core_dst_local = lo;
    core_data = d;
    while (!core_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 20) check("push_timeout", 32'(waited), 32'd0);
    @(negedge clk);
  endtask

  int unsigned nflits;

  initial begin
    // 1. Reset
    repeat (2) @(negedge clk);
    rst = 1'b1;
    check("rst_flit_valid", 32'(flit_valid), 32'd0);
    check("rst_core_ready", 32'(core_ready), 32'd1);
    check("rst_credit_cnt", 32'(credit_cnt), 32'd4);
    check("rst_fifo_count", 32'(fifo_count), 32'd0);
    check("rst_credit_err", 32'(credit_err), 32'd0);

    // 2. Single push: {2'b10,2'b01,16'hBEEF} = 20'h9BEEF
    push(2'd2, 2'd1, 16'hBEEF);
    core_valid = 1'b0;
    check("single_valid_early", 32'(flit_valid), 32'd0);
    @(negedge clk);
    check("single_valid", 32'(flit_valid), 32'd1);
    check("single_flit", 32'(flit_out), 32'h9BEEF);
    check("single_credit", 32'(credit_cnt), 32'd3);
    @(negedge clk);
    check("single_pulse", 32'(flit_valid), 32'd0);
    check("single_hold", 32'(flit_out), 32'h9BEEF);

    // 3. Six back-to-back pushes without credit return
    do_reset();
    for (int i = 0; i < 6; i++) push(2'(i), 2'(3 - i), 16'h1000 + 16'(i));
    core_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("stall_fifo", 32'(fifo_count), 32'd2);
    check("stall_credit", 32'(credit_cnt), 32'd0);
    check("stall_valid", 32'(flit_valid), 32'd0);
    ci = 1'b1;
    @(negedge clk);
    ci = 1'b0;
    nflits = 0;
    repeat (5) begin
      @(negedge clk);
      if (flit_valid) nflits++;
    end
    check("release_one", nflits, 32'd1);
    check("release_fifo", 32'(fifo_count), 32'd1);
    check("release_flit", 32'(flit_out), {12'd0, 2'd0, 2'd3, 16'h1004} | 32'h0);

    // 4. Continuous push with steady credit return
    do_reset();
    nflits = 0;
    for (int i = 0; i < 14; i++) begin
      push(2'(i), 2'(i >> 2), 16'hA000 + 16'(i));
      if (flit_valid) begin
        ci = 1'b1;
        nflits++;
      end
      if (i >= 4) check("stream_credit", 32'(credit_cnt), 32'd3);
    end
    core_valid = 1'b0;
    ci = 1'b0;
    check("stream_flits", nflits, 32'd13);
    repeat (3) @(negedge clk);

    // 5. Credit returned at full count
    do_reset();
    ci = 1'b1;
    @(negedge clk);
    ci = 1'b0;
    check("err_credit", 32'(credit_cnt), 32'd4);
    check("err_set", 32'(credit_err), 32'd1);
    repeat (3) @(negedge clk);
    check("err_sticky", 32'(credit_err), 32'd1);

    // 6. Reset with 3 queued entries and one credit
    for (int i = 0; i < 7; i++) push(2'd3, 2'd3, 16'h5000 + 16'(i));
    core_valid = 1'b0;
    ci = 1'b1;
    @(negedge clk);
    ci = 1'b0;
    check("pre_rst_fifo", 32'(fifo_count), 32'd3);
    check("pre_rst_credit", 32'(credit_cnt), 32'd1);
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_fifo", 32'(fifo_count), 32'd0);
    check("mid_rst_credit", 32'(credit_cnt), 32'd4);
    check("mid_rst_valid", 32'(flit_valid), 32'd0);
    check("mid_rst_err", 32'(credit_err), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    nflits = 0;
    repeat (4) begin
      @(negedge clk);
      if (flit_valid) nflits++;
    end
    check("post_rst_quiet", nflits, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
